// File: rtl/lf_prefix_carry_seq.sv
// rtl/lf_prefix_carry_seq.sv - iterative Ladner-Fischer carry prefix, one tree level per clock
//
// Takes operands a, b and carry-in. Forms bitwise generate/propagate at accept,
// then resolves one prefix level per clock. Presents the carry vector c and the
// propagate vector p so a sum stage can form s = c ^ p.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake; in_ready is high only while idle
//   a, b, cin            operands and carry-in
//   out_valid/out_ready  result handshake; result is held until accepted
//   c                    carry into each bit (c[0] = cin)
//   p                    a ^ b, captured at accept
//   cout                 carry out of the top bit

module lf_prefix_carry_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] p,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int IW     = LEVELS;
    localparam int LW     = $clog2(LEVELS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        PREFIX,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] pp;
    logic             cin_r;
    logic [LW-1:0]    lvl;

    logic [WIDTH-1:0] g_nxt;
    logic [WIDTH-1:0] pp_nxt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    blk;
    logic [IW-1:0]    j;

    assign in_ready = (state == IDLE);

    // One Sklansky-style level: every bit whose index has bit lvl set combines
    // with the last bit of the preceding 2^lvl block, so after level k each
    // bit holds the group G/P back to the start of its 2^(k+1) block.
    always_comb begin
        g_nxt  = g;
        pp_nxt = pp;
        idx    = '0;
        blk    = '0;
        j      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = IW'(i);
            blk = idx >> lvl;
            if (blk[0]) begin
                j         = (blk << lvl) - IW'(1);
                g_nxt[i]  = g[i] | (pp[i] & g[j]);
                pp_nxt[i] = pp[i] & pp[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            g         <= '0;
            pp        <= '0;
            cin_r     <= 1'b0;
            lvl       <= '0;
            c         <= '0;
            p         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        p     <= a ^ b;
                        pp    <= a ^ b;
                        // Fold carry-in into bit 0 so the tree output is the
                        // true carry out of each bit.
                        g     <= {a[WIDTH-1:1] & b[WIDTH-1:1],
                                  (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};
                        cin_r <= cin;
                        lvl   <= '0;
                        state <= PREFIX;
                    end
                end
                PREFIX: begin
                    g  <= g_nxt;
                    pp <= pp_nxt;
                    if (lvl == LW'(LEVELS - 1)) begin
                        c         <= {g_nxt[WIDTH-2:0], cin_r};
                        cout      <= g_nxt[WIDTH-1];
                        out_valid <= 1'b1;
                        lvl       <= '0;
                        state     <= DONE;
                    end else begin
                        lvl <= lvl + LW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lf_prefix_carry_seq.sv
// tb/tb_lf_prefix_carry_seq.sv - scoreboard bench for lf_prefix_carry_seq

module tb_lf_prefix_carry_seq;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] c;
    logic [W-1:0] p;
    logic         cout;

    int checks = 0;
    int errors = 0;

    bit stall_mode = 1'b0;
    bit ready_ctl  = 1'b1;

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] p;
        logic         cout;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    lf_prefix_carry_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .p         (p),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        out_ready = stall_mode ? ($urandom_range(0, 3) != 0) : ready_ctl;
    end

    // Monitor: a result is consumed on the edge after a negedge that sees
    // out_valid & out_ready, so compare exactly once per result here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result c=%h p=%h cout=%b (no result expected)", c, p, cout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (c !== e.c || p !== e.p || cout !== e.cout) begin
                    errors++;
                    $display("FAIL %s got c=%h p=%h cout=%b want c=%h p=%h cout=%b",
                             e.name, c, p, cout, e.c, e.p, e.cout);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input bit push, input string nm,
                        input logic [W-1:0] ec, input logic [W-1:0] ep, input logic eco);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_in_ready_timeout got in_ready=0 want 1", nm);
            return;
        end
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
        if (push) begin
            e.c = ec;
            e.p = ep;
            e.cout = eco;
            e.name = nm;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc, input string nm);
        logic [W:0]   sum;
        logic [W-1:0] pm;
        sum = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
        pm = va ^ vb;
        send(va, vb, vc, 1'b1, nm, sum[W-1:0] ^ pm, pm, sum[W]);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL %s_drain_timeout got pending=%0d want 0", nm, exp_q.size());
        end
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};

    initial begin
        logic [W-1:0] hc, hp;
        logic         hco;
        logic [W-1:0] ra, rb;
        int lat;

        #2;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_c", c, 64'd0);
        chk("reset_p", p, 64'd0);
        chk("reset_cout", {63'd0, cout}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        send(64'd29, 64'd5, 1'b0, 1'b1, "t1_29_5", 64'h3A, 64'h18, 1'b0);
        send(ONES, 64'd0, 1'b1, 1'b1, "t2_ones_cin", ONES, ONES, 1'b1);
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1, "t3_alt", 64'd0, ONES, 1'b0);
        send(64'd0, 64'd0, 1'b1, 1'b1, "zero_cin", 64'd1, 64'd0, 1'b0);
        send(ONES, ONES, 1'b0, 1'b1, "ones_ones", 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b1);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, "msb_msb_cin", 64'd1, 64'd0, 1'b1);
        drain("directed");

        ready_ctl = 1'b0;
        @(posedge clk);
        #1;
        send(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b1, "t4_backpressure",
             64'hFFFF_FFFE_0000_0000, 64'hFFFF_FFFE_0000_0000, 1'b1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t4_latency", 64'(lat), 64'd6);
        hc = c;
        hp = p;
        hco = cout;
        for (int k = 0; k < 10; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            cin = k[0];
            in_valid = k[0];
            @(posedge clk);
            #1;
            chk("t4_hold", {c ^ hc} | {p ^ hp} | {63'd0, cout ^ hco} | {63'd0, ~out_valid}, 64'd0);
            chk("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        ready_ctl = 1'b1;
        drain("t4");

        send(64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444, 1'b1, 1'b0, "t5_aborted", '0, '0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_rst_c", c, 64'd0);
        chk("t5_rst_p", p, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
        send(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, "t5_after_rst",
             64'hFDF9_FDF1_FDF9_FDE0, 64'hECE8_ECE0_ECE8_ECE0, 1'b1);
        drain("t5");

        stall_mode = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = ~ra;
                1: ra = ONES;
                2: rb = '0;
                default: ;
            endcase
            send_model(ra, rb, 1'($urandom_range(0, 1)), "t6_random");
        end
        drain("t6");
        stall_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
